// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers the hex frame shown on a multiplexed active-low 7-segment bus
module seg7_scan_decoder #(
  parameter int NDIG        = 6,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [7:0]      iSEG,
  input  logic [NDIG-1:0] iDIG_EN,
  output logic [31:0]     oDIG,
  output logic [NDIG-1:0] oDP,
  output logic            oVALID,
  output logic            oERR,
  output logic            oTIMEOUT
);
  localparam int SW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(STABLE_CYC + 1);
  typedef enum logic [1:0] {SYNC, COLLECT, PUBLISH} state_t;
  state_t            r_state, w_state_nx;
  logic [7:0]        r_seg_m, r_seg_s, r_seg_p;
  logic [NDIG-1:0]   r_en_m, r_en_s, r_en_p;
  logic [CW-1:0]     r_cnt, w_cnt_nx;
  logic [NDIG-1:0]   w_act;
  logic              w_onehot, w_same, w_commit, w_acc;
  logic [SW-1:0]     w_sel;
  logic [4:0]        w_dec;
  logic [NDIG-1:0]   r_seen, r_errm, r_dpm, w_seen_nx, w_errm_nx, w_dpm_nx;
  logic [4*NDIG-1:0] r_nib, w_nib_nx;
  logic [15:0]       r_timer, w_timer_nx;
  logic              w_pub, w_to, w_ferr;
  logic [31:0]       r_dig;
  logic [NDIG-1:0]   r_dp;
  logic              r_valid, r_err, r_to;

  // Pattern to {err, nibble}; blank reads as E and a lone dash as F
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h18: decode = 5'h09;
      7'h08: decode = 5'h0A;
      7'h03: decode = 5'h0B;
      7'h46: decode = 5'h0C;
      7'h21: decode = 5'h0D;
      7'h7F: decode = 5'h0E;
      7'h3F: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  assign w_act    = ~r_en_s;
  assign w_onehot = (w_act != '0) && ((w_act & (w_act - NDIG'(1))) == '0);
  assign w_same   = (r_en_s == r_en_p) && (r_seg_s == r_seg_p);
  assign w_cnt_nx = !w_onehot ? '0 : !w_same ? CW'(1) : (r_cnt == CW'(STABLE_CYC)) ? r_cnt : r_cnt + CW'(1);
  assign w_commit = (w_cnt_nx == CW'(STABLE_CYC)) && (r_cnt != CW'(STABLE_CYC));
  assign w_dec    = decode(r_seg_s[6:0]);
  assign w_acc    = w_commit && (r_state == COLLECT || w_sel == '0);

  // Index of the single active select line
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NDIG; k++) if (w_act[k]) w_sel = SW'(k);
  end

  // Two-flop input synchronizer, previous-cycle copy and dwell counter
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_seg_m <= '1;
      r_seg_s <= '1;
      r_seg_p <= '1;
      r_en_m  <= '1;
      r_en_s  <= '1;
      r_en_p  <= '1;
      r_cnt   <= '0;
    end else begin
      r_seg_m <= iSEG;
      r_seg_s <= r_seg_m;
      r_seg_p <= r_seg_s;
      r_en_m  <= iDIG_EN;
      r_en_s  <= r_en_m;
      r_en_p  <= r_en_s;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Frame assembly and state transitions; completion is checked before the timeout
  always_comb begin
    w_state_nx = r_state;
    w_seen_nx  = r_seen;
    w_errm_nx  = r_errm;
    w_nib_nx   = r_nib;
    w_dpm_nx   = r_dpm;
    w_timer_nx = r_timer;
    w_pub      = 1'b0;
    w_to       = 1'b0;
    if (w_acc) begin
      w_nib_nx[4*w_sel +: 4] = w_dec[3:0];
      w_dpm_nx[w_sel]        = ~r_seg_s[7];
      w_errm_nx[w_sel]       = w_dec[4];
      w_seen_nx[w_sel]       = 1'b1;
    end
    w_ferr = |w_errm_nx;
    if (r_state == COLLECT) begin
      w_timer_nx = r_timer + 16'd1;
      if (&w_seen_nx) begin
        w_pub      = 1'b1;
        w_seen_nx  = '0;
        w_errm_nx  = '0;
        w_state_nx = PUBLISH;
      end else if (r_timer == 16'(TIMEOUT_CYC - 1)) begin
        w_to       = 1'b1;
        w_seen_nx  = '0;
        w_errm_nx  = '0;
        w_state_nx = SYNC;
      end
    end else begin
      w_timer_nx = w_acc ? '0 : r_timer;
      w_state_nx = w_acc ? COLLECT : SYNC;
    end
  end

  // State, frame store and registered outputs
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= SYNC;
      r_seen  <= '0;
      r_errm  <= '0;
      r_nib   <= '0;
      r_dpm   <= '0;
      r_timer <= '0;
      r_dig   <= '0;
      r_dp    <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_seen  <= w_seen_nx;
      r_errm  <= w_errm_nx;
      r_nib   <= w_nib_nx;
      r_dpm   <= w_dpm_nx;
      r_timer <= w_timer_nx;
      r_dig   <= w_pub ? 32'(w_nib_nx) : r_dig;
      r_dp    <= w_pub ? w_dpm_nx : r_dp;
      r_err   <= w_pub ? w_ferr : r_err;
      r_valid <= w_pub;
      r_to    <= w_to;
    end
  end

  assign oDIG     = r_dig;
  assign oDP      = r_dp;
  assign oVALID   = r_valid;
  assign oERR     = r_err;
  assign oTIMEOUT = r_to;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and random scans checked against a frame-level model
module tb_seg7_scan_decoder;
  logic        iCLK = 1'b0;
  logic        iRST;
  logic [7:0]  iSEG;
  logic [5:0]  iDIG_EN;
  logic [31:0] oDIG;
  logic [5:0]  oDP;
  logic        oVALID, oERR, oTIMEOUT;
  int          total = 0, bad = 0, n_valid = 0, n_to = 0;
  logic [31:0] cap_dig;
  logic [5:0]  cap_dp;
  logic        cap_err;
  logic [6:0]  enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h7F, 7'h3F};

  always #5 iCLK = ~iCLK;

  seg7_scan_decoder #(.NDIG(6), .STABLE_CYC(4), .TIMEOUT_CYC(100)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSEG(iSEG), .iDIG_EN(iDIG_EN),
    .oDIG(oDIG), .oDP(oDP), .oVALID(oVALID), .oERR(oERR), .oTIMEOUT(oTIMEOUT)
  );

  // Records every publish and timeout pulse
  always @(negedge iCLK) begin
    if (oVALID) begin
      n_valid++;
      cap_dig = oDIG;
      cap_dp  = oDP;
      cap_err = oERR;
    end
    if (oTIMEOUT) n_to++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] code(input int v, input bit dp);
    return {~dp, enc[v]};
  endfunction

  function automatic logic [47:0] frame_of(input logic [23:0] nibs, input logic [5:0] dps);
    logic [47:0] s;
    for (int k = 0; k < 6; k++) s[8*k +: 8] = code(int'(nibs[4*k +: 4]), dps[k]);
    return s;
  endfunction

  function automatic bit in_table(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (enc[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic show(input int k, input logic [7:0] s, input int n);
    iDIG_EN = ~(6'b000001 << k);
    iSEG    = s;
    repeat (n) @(negedge iCLK);
  endtask

  task automatic idle(input int n);
    iDIG_EN = '1;
    iSEG    = '1;
    repeat (n) @(negedge iCLK);
  endtask

  task automatic scan(input logic [47:0] segs, input int lo, input int hi, input int gk, input logic [7:0] gseg);
    for (int k = lo; k <= hi; k++) begin
      if (k == gk) show(k, gseg, 3);
      show(k, segs[8*k +: 8], 8);
    end
    idle(12);
  endtask

  task automatic frame_check(input string tag, input int v0, input logic [31:0] ed, input logic [5:0] edp, input logic ee);
    chk({tag, "_count"}, 32'(n_valid - v0), 32'd1);
    chk({tag, "_dig"}, cap_dig, ed);
    chk({tag, "_dp"}, 32'(cap_dp), 32'(edp));
    chk({tag, "_err"}, 32'(cap_err), 32'(ee));
  endtask

  initial begin
    int v0, t0, w;
    logic [47:0] segs;
    logic [31:0] ed;
    logic [5:0]  edp;
    logic        ee;
    iRST = 1'b1;
    iSEG = '1;
    iDIG_EN = '1;
    repeat (3) @(negedge iCLK);
    chk("rst_dig", oDIG, 32'd0);
    chk("rst_flags", {26'd0, oDP}, 32'd0);
    chk("rst_pulses", {29'd0, oVALID, oERR, oTIMEOUT}, 32'd0);
    iRST = 1'b0;
    idle(4);
    v0 = n_valid;
    scan(frame_of(24'h123456, 6'b0), 0, 5, -1, 8'hFF);
    frame_check("basic", v0, 32'h00123456, 6'b0, 1'b0);
    v0 = n_valid;
    scan(frame_of(24'h123456, 6'b0), 0, 5, 2, 8'hF9);
    frame_check("glitch", v0, 32'h00123456, 6'b0, 1'b0);
    v0 = n_valid;
    segs = frame_of(24'h123456, 6'b0);
    segs[31:24] = 8'hFE;
    scan(segs, 0, 5, -1, 8'hFF);
    frame_check("badpat", v0, 32'h00120456, 6'b0, 1'b1);
    v0 = n_valid;
    segs = frame_of(24'h000000, 6'b0);
    segs[7:0]  = 8'hFF;
    segs[15:8] = 8'h3F;
    scan(segs, 0, 5, -1, 8'hFF);
    frame_check("blankdash", v0, 32'h000000FE, 6'b000010, 1'b0);
    v0 = n_valid;
    t0 = n_to;
    scan(frame_of(24'h999999, 6'b0), 0, 3, -1, 8'hFF);
    w = 0;
    while (n_to == t0 && w < 200) begin
      @(negedge iCLK);
      w++;
    end
    chk("timeout_pulse", 32'(n_to - t0), 32'd1);
    chk("timeout_novalid", 32'(n_valid - v0), 32'd0);
    chk("timeout_hold", oDIG, 32'h000000FE);
    iDIG_EN = 6'b110011;
    iSEG = code(0, 1'b0);
    repeat (20) @(negedge iCLK);
    iDIG_EN = 6'b111100;
    repeat (20) @(negedge iCLK);
    idle(150);
    chk("multisel_noto", 32'(n_to - t0), 32'd1);
    chk("multisel_novalid", 32'(n_valid - v0), 32'd0);
    v0 = n_valid;
    scan(frame_of(24'hFEDCBA, 6'b101010), 0, 5, -1, 8'hFF);
    frame_check("after_to", v0, 32'h00FEDCBA, 6'b101010, 1'b0);
    scan(frame_of(24'hAAAAAA, 6'b0), 0, 3, -1, 8'hFF);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("midrst_dig", oDIG, 32'd0);
    chk("midrst_flags", {26'd0, oDP}, 32'd0);
    chk("midrst_pulses", {29'd0, oVALID, oERR, oTIMEOUT}, 32'd0);
    iRST = 1'b0;
    idle(4);
    v0 = n_valid;
    show(4, code(7, 1'b0), 8);
    show(5, code(7, 1'b0), 8);
    idle(12);
    scan(frame_of(24'h654321, 6'b000001), 0, 5, -1, 8'hFF);
    frame_check("postrst", v0, 32'h00654321, 6'b000001, 1'b0);
    for (int f = 0; f < 8; f++) begin
      int gk;
      ed = '0;
      edp = '0;
      ee = 1'b0;
      for (int k = 0; k < 6; k++) begin
        int v;
        bit dp;
        logic [6:0] p;
        v  = int'($urandom_range(0, 15));
        dp = 1'($urandom_range(0, 1));
        edp[k] = dp;
        if ($urandom_range(0, 4) == 0) begin
          p = 7'($urandom_range(0, 127));
          while (in_table(p)) p = 7'($urandom_range(0, 127));
          segs[8*k +: 8] = {~dp, p};
          ee = 1'b1;
        end else begin
          segs[8*k +: 8] = code(v, dp);
          ed = ed | (32'(v) << (4*k));
        end
      end
      gk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : -1;
      v0 = n_valid;
      scan(segs, 0, 5, gk, 8'($urandom_range(0, 255)));
      frame_check($sformatf("rand%0d", f), v0, ed, edp, ee);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
